// File: rtl/mux_rr_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// mux_sched_pkg
//   Shared types and constants for the round-robin mux scheduler.
//   - state_t : FSM encoding (ST_IDLE=0, ST_GRANT=1)
//   - N_REQ / SEL_W : requester count and select width (match mux_16_1)
//   - GCNT_W : width of the optional grant statistics counter
//   - BEAT_W : width of the per-grant beat counter (HOLD_MAX <= 255)
// ---------------------------------------------------------------------------
package mux_sched_pkg;

  localparam int N_REQ  = 16;
  localparam int SEL_W  = 4;
  localparam int GCNT_W = 16;
  localparam int BEAT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// mux_rr_scheduler_if
//   Bundles the scheduler's request, handshake and mux-control signals.
//   Optional feature macro: MUX_SCHED_STATS_EN (adds grant_cnt).
//
//   Signals:
//     en         scheduler enable, gates new grants only
//     req        one request bit per mux input din_0..din_15
//     out_ready  downstream accepts the current mux Y beat
//     sel        registered select to mux_16_1
//     grant      registered one-hot grant, 0 when idle
//     out_valid  mux Y beat is valid (combinational)
//     busy       registered, high while a grant is active
//     dbg_state  FSM state for checkers (0 idle, 1 grant)
//     dbg_ptr    current round-robin highest-priority index
//     grant_cnt  saturating count of grants issued (stats build only)
//
//   Handshake: a beat transfers on a rising clk edge where out_valid and
//   out_ready are both 1. out_valid never depends on out_ready; out_ready
//   may be held low indefinitely (the burst just stalls). out_valid drops
//   in the same cycle the granted requester withdraws its req bit.
//
//   Modports: master = scheduler side, slave = requesters/downstream side.
// ---------------------------------------------------------------------------
interface mux_rr_scheduler_if;
  import mux_sched_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] grant;
  logic             out_valid;
  logic             busy;
  logic             dbg_state;
  logic [SEL_W-1:0] dbg_ptr;
`ifdef MUX_SCHED_STATS_EN
  logic [GCNT_W-1:0] grant_cnt;

  modport master (
    input  en, req, out_ready,
    output sel, grant, out_valid, busy, dbg_state, dbg_ptr, grant_cnt
  );
  modport slave (
    output en, req, out_ready,
    input  sel, grant, out_valid, busy, dbg_state, dbg_ptr, grant_cnt
  );
`else
  modport master (
    input  en, req, out_ready,
    output sel, grant, out_valid, busy, dbg_state, dbg_ptr
  );
  modport slave (
    output en, req, out_ready,
    input  sel, grant, out_valid, busy, dbg_state, dbg_ptr
  );
`endif

endinterface

// File: rtl/mux_rr_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotate-priority picker.
//   Ports:
//     req   in  16  request vector
//     ptr   in  4   highest-priority index
//     idx   out 4   first set request at or after ptr (wrapping mod 16)
//     found out 1   any request set
//   Method: rotate req right by ptr so ptr lands at bit 0, take the lowest
//   set bit, then add ptr back (4-bit add wraps modulo 16).
// ---------------------------------------------------------------------------
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]   w_pe;

  always_comb begin
    w_dbl = {req, req};
    w_rot = w_dbl[ptr +: N_REQ];
    w_pe  = '0;
    // Scan downward so the lowest set bit wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pe = SEL_W'(i);
    end
    idx   = w_pe + ptr;
    found = |req;
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux_rr_scheduler
//   Round-robin scheduler sharing one mux_16_1 among 16 requesters. Drives
//   the mux select, a one-hot grant, and qualifies mux Y with valid/ready.
//   Each grant is capped at HOLD_MAX accepted beats, and one IDLE guard
//   cycle always separates consecutive grants so the mux can settle.
//   Optional feature macro: MUX_SCHED_STATS_EN (grant_cnt output/counter).
//
//   Parameters:
//     HOLD_MAX  max accepted beats per grant, legal range 1..255
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   asynchronous active-high reset
//     sched_if  master modport of mux_rr_scheduler_if (see interface file)
// ---------------------------------------------------------------------------
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  mux_rr_scheduler_if.master  sched_if
);

  localparam logic [BEAT_W-1:0] LP_LAST_BEAT = BEAT_W'(HOLD_MAX - 1);

  state_t            r_state,    w_state_nx;
  logic [SEL_W-1:0]  r_sel,      w_sel_nx;
  logic [SEL_W-1:0]  r_ptr,      w_ptr_nx;
  logic [N_REQ-1:0]  r_grant,    w_grant_nx;
  logic [BEAT_W-1:0] r_beat_cnt, w_beat_nx;
  logic              r_busy;

  logic              w_out_valid;
  logic              w_accept;
  logic [SEL_W-1:0]  w_idx;
  logic              w_found;

  rr_pick u_pick (
    .req   (sched_if.req),
    .ptr   (r_ptr),
    .idx   (w_idx),
    .found (w_found)
  );

  // Valid only while granted and the owner still requests; sel is frozen
  // during GRANT, so mux Y cannot glitch while this is high.
  assign w_out_valid = (r_state == ST_GRANT) && sched_if.req[r_sel];
  assign w_accept    = w_out_valid && sched_if.out_ready;

  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_ptr_nx   = r_ptr;
    w_grant_nx = r_grant;
    w_beat_nx  = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (sched_if.en && w_found) begin
          w_state_nx = ST_GRANT;
          w_sel_nx   = w_idx;
          w_grant_nx = N_REQ'(1) << w_idx;
          w_beat_nx  = '0;
        end
      end
      ST_GRANT: begin
        // Withdrawal is checked first: with req[sel]==0 no beat can be
        // accepted, so it naturally takes priority over the beat limit.
        if (!sched_if.req[r_sel]) begin
          w_state_nx = ST_IDLE;
          w_ptr_nx   = r_sel + SEL_W'(1);
          w_grant_nx = '0;
        end else if (w_accept) begin
          if (r_beat_cnt == LP_LAST_BEAT) begin
            w_state_nx = ST_IDLE;
            w_ptr_nx   = r_sel + SEL_W'(1);
            w_grant_nx = '0;
          end else begin
            w_beat_nx = r_beat_cnt + BEAT_W'(1);
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_sel      <= w_sel_nx;
      r_ptr      <= w_ptr_nx;
      r_grant    <= w_grant_nx;
      r_beat_cnt <= w_beat_nx;
      r_busy     <= (w_state_nx == ST_GRANT);
    end
  end

`ifdef MUX_SCHED_STATS_EN
  logic [GCNT_W-1:0] r_grant_cnt;
  logic              w_start;

  assign w_start = (r_state == ST_IDLE) && (w_state_nx == ST_GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt <= '0;
    end else if (w_start && (r_grant_cnt != {GCNT_W{1'b1}})) begin
      r_grant_cnt <= r_grant_cnt + GCNT_W'(1);
    end
  end

  assign sched_if.grant_cnt = r_grant_cnt;
`endif

  assign sched_if.sel       = r_sel;
  assign sched_if.grant     = r_grant;
  assign sched_if.out_valid = w_out_valid;
  assign sched_if.busy      = r_busy;
  assign sched_if.dbg_state = r_state;
  assign sched_if.dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_scheduler
//   Self-checking bench for mux_rr_scheduler. A reference model tracks the
//   current owner, round-robin pointer and accepted-beat count directly from
//   the arbitration rules; expected beats go into exp_q and a monitor pops
//   them whenever the DUT presents an accepted beat.
//   Optional feature macro: MUX_SCHED_STATS_EN (grant_cnt also checked).
// ---------------------------------------------------------------------------
module tb_mux_rr_scheduler;

  localparam int HOLD_MAX = 8;

  logic clk;
  logic rst;

  mux_rr_scheduler_if vif();

  mux_rr_scheduler #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .sched_if (vif)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic [19:0] exp_q[$];   // {sel, one-hot grant} per expected accepted beat
  int grant_log[$];        // sel observed at each DUT grant start

  // Reference model
  int m_owner;   // -1 when no grant is active
  int m_ptr;
  int m_sel;
  int m_beats;
  int m_grants;
  bit prev_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_sel     = 0;
    m_beats   = 0;
    m_grants  = 0;
    prev_busy = 1'b0;
    exp_q.delete();
  endtask

  // Compare this cycle's outputs to the model, queue any expected beat,
  // then advance the model across the coming clock edge.
  task automatic eval();
    logic [15:0] r;
    bit          granted;
    bit          exp_valid;
    logic [15:0] exp_grant;
    int          win;
    r         = vif.req;
    granted   = (m_owner >= 0);
    exp_valid = granted && r[m_owner];
    exp_grant = granted ? (16'd1 << m_owner) : 16'd0;

    check("busy",      32'(vif.busy),      32'(granted));
    check("out_valid", 32'(vif.out_valid), 32'(exp_valid));
    check("grant",     32'(vif.grant),     32'(exp_grant));
    check("sel",       32'(vif.sel),       32'(m_sel));
    check("ptr",       32'(vif.dbg_ptr),   32'(m_ptr));
`ifdef MUX_SCHED_STATS_EN
    check("grant_cnt", 32'(vif.grant_cnt), 32'(m_grants));
`endif

    if (vif.busy && !prev_busy) grant_log.push_back(int'(vif.sel));
    prev_busy = vif.busy;

    if (exp_valid && vif.out_ready) exp_q.push_back({4'(m_sel), exp_grant});

    if (!granted) begin
      if (vif.en && r != 16'd0) begin
        win = -1;
        for (int k = 0; k < 16; k++) begin
          if (win < 0 && r[(m_ptr + k) % 16]) win = (m_ptr + k) % 16;
        end
        m_owner = win;
        m_sel   = win;
        m_beats = 0;
        if (m_grants < 65535) m_grants++;
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 16;
      m_owner = -1;
    end else if (vif.out_ready) begin
      m_beats++;
      if (m_beats == HOLD_MAX) begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [15:0] r, input logic e, input logic rdy);
    @(negedge clk);
    vif.req       = r;
    vif.en        = e;
    vif.out_ready = rdy;
    #1;
    eval();
  endtask

  // Release reset at a falling edge and evaluate that cycle immediately so
  // the model sees the first arbitration edge after release.
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    eval();
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [19:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && vif.out_valid && vif.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL beat_unexpected: got sel %0d with no expected beat at %0t", vif.sel, $time);
        end else begin
          exp = exp_q.pop_front();
          check("beat", 32'({vif.sel, vif.grant}), 32'(exp));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] r_cur;
    int          g;
    int          ph;
    rst           = 1'b1;
    vif.req       = 16'd0;
    vif.en        = 1'b1;
    vif.out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    release_reset();

    // Idle with no requests: everything stays cleared.
    repeat (20) step(16'd0, 1'b1, 1'b1);

    // Fixed pattern from reset: 0, 2, 5, 12, then wrap to 0.
    grant_log.delete();
    repeat (45) step(16'h1025, 1'b1, 1'b1);
    g = (grant_log.size() >= 5) ? 1 : 0;
    check("seq_count", 32'(g), 32'd1);
    if (grant_log.size() >= 5) begin
      check("seq0", 32'(grant_log[0]), 32'd0);
      check("seq1", 32'(grant_log[1]), 32'd2);
      check("seq2", 32'(grant_log[2]), 32'd5);
      check("seq3", 32'(grant_log[3]), 32'd12);
      check("seq4", 32'(grant_log[4]), 32'd0);
    end
`ifdef MUX_SCHED_STATS_EN
    check("grant_cnt_5", 32'(vif.grant_cnt), 32'd5);
`endif
    repeat (10) step(16'd0, 1'b1, 1'b1);

    // Single requester withdraws after 3 accepted beats.
    for (int i = 0; i < 40 && !(m_owner == 4 && m_beats == 3); i++) step(16'h0010, 1'b1, 1'b1);
    check("drop_reached", 32'(m_owner == 4 && m_beats == 3), 32'd1);
    step(16'h0000, 1'b1, 1'b1);
    check("drop_valid_low", 32'(vif.out_valid), 32'd0);
    step(16'h0000, 1'b1, 1'b1);
    check("drop_grant_zero", 32'(vif.grant), 32'd0);
    check("drop_ptr5", 32'(vif.dbg_ptr), 32'd5);

    // Stalling ready pattern 1,0,0,1: bursts count beats, not cycles.
    for (int i = 0; i < 80; i++) step(16'hFFFF, 1'b1, (i % 4 == 0) || (i % 4 == 3));
    repeat (12) step(16'd0, 1'b1, 1'b1);

    // Wrap: owner 15 then 0 requesting too -> next grant is 0.
    for (int i = 0; i < 40 && m_owner != 15; i++) step(16'h8000, 1'b1, 1'b1);
    check("wrap_owner15", 32'(m_owner), 32'd15);
    for (int i = 0; i < 40 && m_owner == 15; i++) step(16'h8001, 1'b1, 1'b1);
    grant_log.delete();
    repeat (3) step(16'h8001, 1'b1, 1'b1);
    g = (grant_log.size() > 0) ? grant_log[0] : -1;
    check("wrap_next0", 32'(g), 32'd0);

    // en low mid-burst: burst completes, no new grant afterwards.
    repeat (20) step(16'h8001, 1'b0, 1'b1);
    check("en_low_idle", 32'(vif.busy), 32'd0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 60 && !(m_owner >= 0 && m_beats == 4); i++) step(16'h0F0F, 1'b1, 1'b1);
    check("rst_point", 32'(m_owner >= 0 && m_beats == 4), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy",  32'(vif.busy),      32'd0);
    check("rst_grant", 32'(vif.grant),     32'd0);
    check("rst_valid", 32'(vif.out_valid), 32'd0);
    check("rst_sel",   32'(vif.sel),       32'd0);
    check("rst_ptr",   32'(vif.dbg_ptr),   32'd0);
`ifdef MUX_SCHED_STATS_EN
    check("rst_gcnt",  32'(vif.grant_cnt), 32'd0);
`endif
    model_reset();
    vif.req = 16'hFFFF;
    repeat (2) @(posedge clk);
    grant_log.delete();
    release_reset();
    repeat (3) step(16'hFFFF, 1'b1, 1'b1);
    g = (grant_log.size() > 0) ? grant_log[0] : -1;
    check("post_rst_grant0", 32'(g), 32'd0);

    // Randomized traffic.
    r_cur = 16'd0;
    for (int i = 0; i < 3000; i++) begin
      ph = int'($urandom_range(0, 5));
      if (ph == 0) r_cur = 16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535));
      step(r_cur, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
    end

    repeat (12) step(16'd0, 1'b1, 1'b1);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
